pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and flush controller for the in-order RV32I pipeline. It replaces the separate hazard-detection and forwarding units. A depth-parametrised scoreboard tracks the destination register of every instruction past decode. It generates PC/F-D stall, bubble injection and flush, and registered per-operand forwarding selects for the execute stage. It also supports a multi-cycle execute hold (`ex_busy`) for the future M-extension unit, and keeps saturating stall/flush performance counters.

## Interface
- `REG_IDX_W`, 5: register index width.
- `DEPTH`, 3: tracked stages after decode; entry 0 = EX, 1 = MEM, 2 = WB.
- `LOAD_READY`, 2: lowest entry index at which a load result can be forwarded.
- `CNT_W`, 16: performance counter width.
- `FWD_W`, `$clog2(DEPTH)`: forwarding select width (derived, not overridable).
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode holds a valid instruction.
- `id_rs1_idx`, `id_rs2_idx` in REG_IDX_W: decode source indices.
- `id_rs1_used`, `id_rs2_used` in 1: source actually read.
- `id_rd_idx` in REG_IDX_W; `id_wb_en` in 1; `id_is_load` in 1: decode destination info.
- `ex_busy` in 1: EX multi-cycle unit busy, hold EX.
- `br_taken` in 1: the instruction in EX resolved as a taken branch or jump.
- `pc_stall`, `fd_stall` out 1: hold PC and the F-D register.
- `fd_flush` out 1: clear the F-D register.
- `de_flush` out 1: load a bubble into the D-E register.
- `de_stall` out 1: hold the D-E register.
- `em_flush` out 1: load a bubble into the E-M register.
- `fwd1_sel`, `fwd2_sel` out FWD_W: EX operand source; 0 = D-E register data, j = result register of entry j (1 = E-M, 2 = M-W).
- `perf_stall_cnt`, `perf_flush_cnt` out CNT_W: event counters.

## Operation
- Each scoreboard entry holds `{valid, rd, wb_en, is_load}`. An entry matches source s when valid, wb_en, rd == s, rd != 0 and the source is used.
- For each decode source, find the youngest matching entry k (smallest k).
- Load-use hazard: the matching entry is a load and k+1 < LOAD_READY.
- Forward select for the issuing instruction: k+1 if k+1 ≤ DEPTH-1, else 0. The regfile is write-through, so a producer at entry DEPTH-1 resolves to 0.
- Priority order: `ex_busy` > `br_taken` > load-use > normal.
- `ex_busy`:
  - Outputs: pc_stall = fd_stall = de_stall = em_flush = 1.
  - Entry 0 holds, entry 1 becomes invalid, entries ≥ 2 shift from the entry below.
  - Fwd selects hold. `br_taken` is ignored.
- `br_taken`:
  - Outputs: fd_flush = de_flush = 1; no stalls.
  - Entry 0 becomes invalid (the decode instruction is killed); all others shift.
  - Fwd selects become 0.
- Load-use (id_valid = 1):
  - Outputs: pc_stall = fd_stall = de_flush = 1.
  - Entry 0 becomes invalid; others shift; fwd selects become 0.
- Normal:
  - Entry 0 ← decode info, with valid = id_valid; others shift.
  - Fwd selects ← computed values, or 0 if id_valid = 0.
- Counters:
  - perf_stall_cnt increments on any cycle with pc_stall = 1.
  - perf_flush_cnt increments on any cycle with fd_flush = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- All control outputs except fwd selects are combinational from the inputs and the current entries, in the same cycle.
- `fwd*_sel` and the counters are registered. The selects apply to the instruction occupying EX in the cycle after issue.
- Load-use costs exactly LOAD_READY-1 bubble cycles. With defaults: 1 bubble, then fwd sel = 2.
- A taken branch costs 2 bubbles (F-D and D-E killed).
- Reset, asynchronous assertion:
  - All entries invalid, fwd selects 0, counters 0.
  - Combinational outputs follow, with all controls 0 when id_valid = 0 and no busy/branch input.
- Reset deasserted synchronously by the system; first update on the following rising edge.
- Simultaneous events:
  - `br_taken` with a load-use condition: flush only, no stall.
  - `ex_busy` with a taken branch: the branch is re-presented when the busy condition drops.

## Structure
- Package `pipe_ctrl_pkg`:
  - entry struct `sb_entry_t`;
  - fwd select constants `FWD_DE = 0`, `FWD_EM = 1`, `FWD_MW = 2`;
  - a default-depth localparam.
- Sub-module `sb_youngest_match`: combinational priority finder that returns {hit, k, is_load} for one source. Instantiate it twice.
- Scoreboard shift register, stall/flush decode and counters live in `pipe_hazard_ctrl`.

## Test plan
- **Back-to-back ALU RAW:**
  - Stimulus: `add x5` issued, then `sub x6,x5,x1` next cycle.
  - Required: fwd1_sel = 1, no stall.
  - Stimulus: consumer one instruction later.
  - Required: fwd1_sel = 2.
  - Stimulus: consumer two instructions later.
  - Required: fwd1_sel = 0.
- **Load-use:**
  - Stimulus: `lw x7` in EX, decode reads x7.
  - Required: one cycle of pc_stall = fd_stall = de_flush = 1, then fwd sel = 2; perf_stall_cnt = 1.
- **x0 and youngest match:**
  - Stimulus: rd = 0 producer.
  - Required: fwd sel = 0.
  - Stimulus: two in-flight writers of x3.
  - Required: the younger (entry 0) wins, sel = 1.
- **Taken branch:**
  - Stimulus: br_taken = 1 with a dependent load in decode.
  - Required: fd_flush = de_flush = 1, pc_stall = 0; entry 0 invalid; perf_flush_cnt = 1.
- **ex_busy for 3 cycles:**
  - Required: stalls and em_flush held 3 cycles; entry 0 preserved; fwd sel unchanged.
  - Required: after release, the dependent consumer gets sel = 1.
- **Reset and saturation:**
  - Stimulus: assert rst mid-stall.
  - Required: all outputs and counters 0 immediately.
  - Stimulus: CNT_W = 2, 5 stalls.
  - Required: perf_stall_cnt = 3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
// Scoreboard entry layout, forwarding select encodings and default sizes.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W_DEF = 5;
    localparam int DEPTH_DEF     = 3;

    localparam int FWD_DE = 0;
    localparam int FWD_EM = 1;
    localparam int FWD_MW = 2;

    typedef struct packed {
        logic                     valid;
        logic [REG_IDX_W_DEF-1:0] rd;
        logic                     wb_en;
        logic                     is_load;
    } sb_entry_t;

    // True when an in-flight entry will write the register a source reads
    function automatic logic entry_hit(
        input sb_entry_t                e,
        input logic [REG_IDX_W_DEF-1:0] src,
        input logic                     used
    );
        return used && e.valid && e.wb_en &&
               (e.rd == src) && (e.rd != '0);
    endfunction

endpackage

// File: rtl/sb_youngest_match.sv
// sb_youngest_match: finds the youngest scoreboard entry writing one source.
// Returns hit, the entry index and whether that producer is a load.
module sb_youngest_match
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int KW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  sb_entry_t                entries [DEPTH],
    input  logic [REG_IDX_W_DEF-1:0] src,
    input  logic                     used,
    output logic                     hit,
    output logic [KW-1:0]            k,
    output logic                     is_load
);

    // Scan oldest to youngest so the smallest matching index wins
    always_comb begin
        hit     = 1'b0;
        k       = '0;
        is_load = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_hit(entries[i], src, used)) begin
                hit     = 1'b1;
                k       = KW'(i);
                is_load = entries[i].is_load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based stall, flush and forwarding control.
// Also handles the EX multi-cycle hold and saturating perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int   REG_IDX_W  = REG_IDX_W_DEF,
    parameter int   DEPTH      = DEPTH_DEF,
    parameter int   LOAD_READY = 2,
    parameter int   CNT_W      = 16,
    localparam int  FWD_W      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1_idx,
    input  logic [REG_IDX_W-1:0] id_rs2_idx,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] id_rd_idx,
    input  logic                 id_wb_en,
    input  logic                 id_is_load,
    input  logic                 ex_busy,
    input  logic                 br_taken,
    output logic                 pc_stall,
    output logic                 fd_stall,
    output logic                 fd_flush,
    output logic                 de_flush,
    output logic                 de_stall,
    output logic                 em_flush,
    output logic [FWD_W-1:0]     fwd1_sel,
    output logic [FWD_W-1:0]     fwd2_sel,
    output logic [CNT_W-1:0]     perf_stall_cnt,
    output logic [CNT_W-1:0]     perf_flush_cnt
);

    typedef enum logic [1:0] {
        M_NORM,
        M_BUSY,
        M_BRANCH,
        M_LOAD_USE
    } mode_e;

    sb_entry_t        sb_q [DEPTH];
    sb_entry_t        sb_d [DEPTH];
    sb_entry_t        id_entry;
    logic             hit1, hit2;
    logic             ld1, ld2;
    logic [FWD_W-1:0] k1, k2;
    logic             lu1, lu2;
    logic             load_use;
    logic [FWD_W-1:0] sel1_calc, sel2_calc;
    logic [FWD_W-1:0] sel1_d, sel2_d;
    mode_e            mode;

    sb_youngest_match #(
        .DEPTH (DEPTH),
        .KW    (FWD_W)
    ) u_match1 (
        .entries (sb_q),
        .src     (REG_IDX_W_DEF'(id_rs1_idx)),
        .used    (id_rs1_used),
        .hit     (hit1),
        .k       (k1),
        .is_load (ld1)
    );

    sb_youngest_match #(
        .DEPTH (DEPTH),
        .KW    (FWD_W)
    ) u_match2 (
        .entries (sb_q),
        .src     (REG_IDX_W_DEF'(id_rs2_idx)),
        .used    (id_rs2_used),
        .hit     (hit2),
        .k       (k2),
        .is_load (ld2)
    );

    // Load-use detection and forwarding selects for the decode instruction
    always_comb begin
        lu1      = hit1 && ld1 && (int'(k1) + 1 < LOAD_READY);
        lu2      = hit2 && ld2 && (int'(k2) + 1 < LOAD_READY);
        load_use = id_valid && (lu1 || lu2);
        sel1_calc = FWD_W'(FWD_DE);
        sel2_calc = FWD_W'(FWD_DE);
        if (hit1 && (int'(k1) + 1 <= DEPTH - 1))
            sel1_calc = FWD_W'(int'(k1) + 1);
        if (hit2 && (int'(k2) + 1 <= DEPTH - 1))
            sel2_calc = FWD_W'(int'(k2) + 1);
        id_entry = '{
            valid:   id_valid,
            rd:      REG_IDX_W_DEF'(id_rd_idx),
            wb_en:   id_wb_en,
            is_load: id_is_load
        };
    end

    // Resolve simultaneous events: busy beats branch beats load-use
    always_comb begin
        if (ex_busy)
            mode = M_BUSY;
        else if (br_taken)
            mode = M_BRANCH;
        else if (load_use)
            mode = M_LOAD_USE;
        else
            mode = M_NORM;
    end

    // Control outputs, scoreboard next state and next forwarding selects
    always_comb begin
        pc_stall = 1'b0;
        fd_stall = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        de_stall = 1'b0;
        em_flush = 1'b0;
        sel1_d   = fwd1_sel;
        sel2_d   = fwd2_sel;
        sb_d[0]  = sb_q[0];
        for (int i = 1; i < DEPTH; i++)
            sb_d[i] = sb_q[i-1];
        unique case (mode)
            M_BUSY: begin
                pc_stall = 1'b1;
                fd_stall = 1'b1;
                de_stall = 1'b1;
                em_flush = 1'b1;
                sb_d[1]  = '0;
            end
            M_BRANCH: begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                sb_d[0]  = '0;
                sel1_d   = FWD_W'(FWD_DE);
                sel2_d   = FWD_W'(FWD_DE);
            end
            M_LOAD_USE: begin
                pc_stall = 1'b1;
                fd_stall = 1'b1;
                de_flush = 1'b1;
                sb_d[0]  = '0;
                sel1_d   = FWD_W'(FWD_DE);
                sel2_d   = FWD_W'(FWD_DE);
            end
            M_NORM: begin
                sb_d[0] = id_entry;
                sel1_d  = id_valid ? sel1_calc : FWD_W'(FWD_DE);
                sel2_d  = id_valid ? sel2_calc : FWD_W'(FWD_DE);
            end
        endcase
    end

    // Scoreboard shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                sb_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                sb_q[i] <= sb_d[i];
        end
    end

    // Registered forwarding selects seen by the instruction in EX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd1_sel <= '0;
            fwd2_sel <= '0;
        end else begin
            fwd1_sel <= sel1_d;
            fwd2_sel <= sel2_d;
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_stall && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            if (fd_flush && !(&perf_flush_cnt))
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
        end
    end

endmodule
